// File: rtl/nn_pkg.sv
// Shared constants, load-port encodings and feeder state type for the neuron datapath.
package nn_pkg;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 256;
  localparam int FRAME_LEN = 260;
  localparam int BIAS_IDX  = DEPTH;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int IDX_W     = $clog2(FRAME_LEN);

  localparam logic [1:0] SEL_ACT  = 2'd0;
  localparam logic [1:0] SEL_WT   = 2'd1;
  localparam logic [1:0] SEL_BIAS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/feeder_bank.sv
// DEPTH x DATA_W register file with an auto-incrementing write pointer and a
// combinational read port that forwards a same-cycle write to the same address.
module feeder_bank
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (we) begin
      wr_ptr <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Contents survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Forwarding lets a word loaded on the start cycle appear at frame index 0.
  assign rd_data = (we && (wr_ptr == rd_addr)) ? wr_data : mem[rd_addr];
endmodule

// File: rtl/neuron_feeder.sv
// Buffers one frame of activations, weights and bias, then replays it as a
// fixed FRAME_LEN-cycle stream aligned to the neuron's state sequence.
module neuron_feeder
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [1:0]               ld_sel,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     start,
  input  logic                     continuous,
  output logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] w,
  output logic                     frame_sync,
  output logic                     busy,
  output logic                     done
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  feeder_state_t     state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] bias;
  logic [DATA_W-1:0] act_rd;
  logic [DATA_W-1:0] wt_rd;

  logic              ld_fire;
  logic              act_we;
  logic              wt_we;
  logic              bias_we;
  logic              stream_next;
  logic [IDX_W-1:0]  nxt_idx;
  logic [DATA_W-1:0] nxt_din;
  logic [DATA_W-1:0] nxt_w;

  // Handshake: a load word transfers on any clock edge where ld_valid && ld_ready
  // and rst is low; ld_ready depends only on state, never on ld_valid.
  assign ld_ready = (state == IDLE);
  assign ld_fire  = ld_valid && ld_ready && !rst;
  assign act_we   = ld_fire && (ld_sel == SEL_ACT);
  assign wt_we    = ld_fire && (ld_sel == SEL_WT);
  assign bias_we  = ld_fire && (ld_sel == SEL_BIAS);

  feeder_bank u_act (
    .clk     (clk),
    .rst     (rst),
    .we      (act_we),
    .wr_data (ld_data),
    .rd_addr (nxt_idx[ADDR_W-1:0]),
    .rd_data (act_rd)
  );

  feeder_bank u_wt (
    .clk     (clk),
    .rst     (rst),
    .we      (wt_we),
    .wr_data (ld_data),
    .rd_addr (nxt_idx[ADDR_W-1:0]),
    .rd_data (wt_rd)
  );

  always_ff @(posedge clk) begin
    if (bias_we) begin
      bias <= ld_data;
    end
  end

  // Outputs are registered, so the stream is looked up one index ahead.
  always_comb begin
    stream_next = 1'b0;
    nxt_idx     = '0;
    nxt_din     = '0;
    nxt_w       = '0;
    if (state == IDLE) begin
      stream_next = start;
    end else if (state == STREAM) begin
      if (idx == LAST_IDX) begin
        stream_next = continuous;
      end else begin
        stream_next = 1'b1;
        nxt_idx     = idx + 1'b1;
      end
    end
    if (stream_next) begin
      if (nxt_idx < IDX_W'(DEPTH)) begin
        nxt_din = act_rd;
        nxt_w   = wt_rd;
      end else if (nxt_idx == IDX_W'(BIAS_IDX)) begin
        nxt_din = bias;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      din        <= '0;
      w          <= '0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (start) state <= STREAM;
        STREAM: begin
          if (idx == LAST_IDX && !continuous) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      idx        <= stream_next ? nxt_idx : '0;
      busy       <= stream_next;
      frame_sync <= stream_next && (nxt_idx == '0);
      din        <= nxt_din;
      w          <= nxt_w;
    end
  end
endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Upstream stage of the neuron datapath.
- Buffers one frame of 256 signed activations, 256 signed weights and one signed bias, written through a byte-wide valid/ready load port.
- On `start`, replays the buffer as a fixed 260-cycle frame on `din`/`w`, aligned to the neuron's 260-state sequence: indices 0..255 carry products, index 256 carries the bias, 257..259 are idle.
- Raises `frame_sync` on the first frame cycle and `done` after the last, so the neuron and downstream logic stay aligned.

Parameters:
- DATA_W, 8, width of activations, weights and bias.
- DEPTH, 256, activation/weight entries per frame; also the bias frame index.
- FRAME_LEN, 260, total cycles per streamed frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- ld_valid  in  1  load word present.
- ld_ready  out  1  feeder accepts a load word this cycle.
- ld_sel  in  2  target bank: 0 = activations, 1 = weights, 2 = bias, 3 = reserved (word accepted and dropped).
- ld_data  in  DATA_W  signed load word.
- start  in  1  request one streamed frame; honoured only in IDLE.
- continuous  in  1  when high, a new frame starts immediately after each frame ends.
- din  out  DATA_W  signed data to neuron (activation, or bias at index 256).
- w  out  DATA_W  signed weight to neuron.
- frame_sync  out  1  high during frame index 0.
- busy  out  1  high while streaming.
- done  out  1  one-cycle pulse after index FRAME_LEN-1 of a non-continued frame.

Behaviour:
- Reset (sync, `rst`=1 at clk edge):
  - state = IDLE; `din`, `w`, `frame_sync`, `busy`, `done` = 0.
  - Activation and weight write pointers = 0; frame index = 0.
  - Buffer contents are not cleared.
- State machine:
  - IDLE: `ld_ready`=1. `start`=1 → STREAM with index 0 on the next cycle.
  - STREAM: index increments by 1 per cycle, 0..FRAME_LEN-1.
    - At index FRAME_LEN-1 with `continuous`=1 → index wraps to 0 and STREAM continues. `done` does not pulse; `frame_sync` reasserts.
    - At index FRAME_LEN-1 with `continuous`=0 → DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE. `ld_ready`=0. A `start` in DONE is ignored.
- Load port:
  - Word accepted when `ld_valid && ld_ready`.
  - Activations and weights use independent auto-increment pointers; each wraps DEPTH-1 → 0.
  - Bias is a single register, overwritten on every accepted bias word.
  - `ld_ready` = (state == IDLE), a pure function of state.
- Same-cycle `start` and accepted load in IDLE: the write commits; streaming reads it (index 0 is read one cycle later).
- Output timing: `din`, `w` and `frame_sync` are registered and appear in the same cycle as the index they belong to.
- Output mapping for frame index c:
  - c < DEPTH: `din` = act[c], `w` = wt[c].
  - c == DEPTH: `din` = bias, `w` = 0.
  - DEPTH < c < FRAME_LEN: `din` = 0, `w` = 0.
  - Outside STREAM: `din` = 0, `w` = 0.
- Latency: `start` sampled at edge T → `frame_sync`=1 and `din`=act[0] at T+1 → `done`=1 at T+261.
- Write pointers are not reset by streaming. A new load sequence after a frame continues from the current pointer; software loads exactly DEPTH words per bank to realign.
- Dropping `continuous` mid-frame: the current frame completes, then DONE.
- `rst` mid-frame: outputs zero on the next cycle. No `done` pulse. The downstream neuron must be reset together with the feeder.

Decomposition:
- Shared package `nn_pkg`:
  - constants DATA_W, DEPTH, FRAME_LEN, BIAS_IDX (= DEPTH);
  - ld_sel encodings SEL_ACT, SEL_WT, SEL_BIAS;
  - feeder state enum {IDLE, STREAM, DONE}.
- One natural sub-module: `feeder_bank`, a DEPTH×DATA_W register file with write pointer, wrap and combinational read. Instantiate it twice, for activations and weights.

Test Plan:
- Load act[i]=1 and wt[i]=1 for all i, bias=5, `start` → `din`=`w`=1 for 256 cycles with `frame_sync` on the first; then `din`=5, `w`=0; then 3 zero cycles; `done` at T+261.
- Load act[i]=i−128 (i=0..255) and wt[i]=−1 → at frame index c, `din`=c−128 and `w`=−1 (sign intact; `din`=−128 at c=0, `din`=127 at c=255).
- `continuous`=1 for two frames → `frame_sync` at T+1 and T+261; no `done` until `continuous` drops; `done` arrives 260 cycles after the final `frame_sync`.
- Hold `ld_valid` through a frame → `ld_ready`=0 for all 261 busy/DONE cycles; no pointer movement; writes resume once state returns to IDLE.
- Write 257 activation words (the last = 0x7F) → act[0]=0x7F (wrap); streaming shows `din`=0x7F at index 0.
- Assert `rst` at frame index 100 → next cycle `din`=`w`=`frame_sync`=`busy`=0; no `done`; a fresh `start` runs a full 260-cycle frame from index 0 with the buffer contents unchanged.
